// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage owning the PC, feeding a DEPTH-entry {pc, inst} FIFO to decode
//
// Optional feature macro: FETCH_PERF_EN (adds saturating perf counters and their ports)
//
// Ports:
//   clk                clock
//   reset              synchronous reset, active-low (0 = reset)
//   i_redirect_valid   load i_redirect_pc and flush the FIFO this cycle
//   i_redirect_pc      new PC, bits [1:0] forced to 0
//   o_fetch_addr       Icache fetch address, straight from the PC register
//   i_icache_inst      Icache instruction word
//   i_icache_valid     Icache hit for the current o_fetch_addr
//   o_dec_valid        FIFO head valid
//   i_dec_ready        decode accepts head
//   o_dec_pc           PC of head entry
//   o_dec_inst         instruction of head entry
//   o_perf_fetched     [FETCH_PERF_EN] instructions enqueued
//   o_perf_miss_cyc    [FETCH_PERF_EN] cycles spent waiting on the Icache
module fetch_queue #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_redirect_valid,
   input  logic [63:0] i_redirect_pc,
   output logic [63:0] o_fetch_addr,
   input  logic [31:0] i_icache_inst,
   input  logic        i_icache_valid,
   output logic        o_dec_valid,
   input  logic        i_dec_ready,
   output logic [63:0] o_dec_pc,
   output logic [31:0] o_dec_inst
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] o_perf_fetched,
   output logic [31:0] o_perf_miss_cyc
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_t;
   occ_t           r_state, w_state_nxt;
   logic [63:0]    r_pc;
   logic [AW-1:0]  r_wr, r_rd;
   logic [CW-1:0]  r_count, w_count_nxt;
   logic [63:0]    r_mem_pc   [DEPTH];
   logic [31:0]    r_mem_inst [DEPTH];
   logic           w_pop, w_push, w_full;
   logic           w_unused;
   // Low PC bits of a redirect target are defined as zero and never looked at.
   assign w_unused     = &{1'b0, i_redirect_pc[1:0]};
   assign o_fetch_addr = r_pc;
   assign o_dec_valid  = r_state != ST_EMPTY;
   assign w_full       = r_state == ST_FULL;
   assign o_dec_pc     = r_mem_pc[r_rd];
   assign o_dec_inst   = r_mem_inst[r_rd];
   assign w_pop        = o_dec_valid & i_dec_ready;
   // A full FIFO still accepts a hit when the head leaves in the same cycle.
   assign w_push       = i_icache_valid & (~w_full | w_pop) & ~i_redirect_valid;
   always_comb begin
      w_count_nxt = r_count;
      w_state_nxt = r_state;
      w_count_nxt = i_redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      w_state_nxt = (w_count_nxt == '0)         ? ST_EMPTY :
                    (w_count_nxt == CW'(DEPTH)) ? ST_FULL  : ST_PARTIAL;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc    <= RESET_PC;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_state <= ST_EMPTY;
      end else begin
         r_count <= w_count_nxt;
         r_state <= w_state_nxt;
         if (i_redirect_valid) begin
            // A same-cycle pop still completes; everything else is discarded.
            r_pc <= {i_redirect_pc[63:2], 2'b00};
            r_wr <= '0;
            r_rd <= '0;
         end else begin
            if (w_push) begin
               r_pc <= r_pc + 64'd4;
               r_wr <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset && w_push) begin
         r_mem_pc[r_wr]   <= r_pc;
         r_mem_inst[r_wr] <= i_icache_inst;
      end
   end
`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched, r_perf_miss_cyc;
   logic        w_miss;
   assign w_miss          = ~i_icache_valid & ~i_redirect_valid & ~w_full;
   assign o_perf_fetched  = r_perf_fetched;
   assign o_perf_miss_cyc = r_perf_miss_cyc;
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_perf_fetched  <= '0;
         r_perf_miss_cyc <= '0;
      end else begin
         if (w_push && r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + 32'd1;
         if (w_miss && r_perf_miss_cyc != '1) r_perf_miss_cyc <= r_perf_miss_cyc + 32'd1;
      end
   end
`endif
endmodule
